// File: rtl/exec_sequencer.sv
// Sequences one instruction: register read, ALU execute, writeback, done pulse.
// Latency: start sampled at edge N -> rf_we in N+3, done in N+4, IDLE again in N+5.
// Backpressure: none; start is only honoured in IDLE, abort cancels at any point.
module exec_sequencer #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       instruction,
  output logic              busy,
  output logic              done,
  output logic [2:0]        pst,
  output logic [3:0]        rf_raddr1,
  output logic [3:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [CNT_W-1:0]  exec_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       ir;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] imm;
  logic              is_nop;
  logic              is_ldi;

  assign is_nop = (ir[15:12] == 4'hF);
  assign is_ldi = (ir[15:12] == 4'hE);
  // LDI immediate is zero-extended or truncated to the datapath width
  assign imm    = DATA_W'(ir[11:8]);

  // Datapath outputs are pure functions of the held instruction and read data
  assign pst       = state;
  assign rf_raddr1 = ir[11:8];
  assign rf_raddr2 = ir[7:4];
  assign alu_op    = ir[15:12];
  assign alu_a     = rf_rdata1;
  assign alu_b     = rf_rdata2;
  assign rf_waddr  = ir[3:0];
  assign rf_wdata  = wb_data;

  // Next-state and strobe decode; abort overrides everything and kills the strobes
  always_comb begin
    state_nxt = IDLE;
    rf_we     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: state_nxt = start ? READ : IDLE;
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        state_nxt = DONE;
        rf_we     = !is_nop;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      rf_we     = 1'b0;
      done      = 1'b0;
    end
  end

  // State register with registered busy flag derived from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Instruction latch on accepted start, and writeback value capture at end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      ir      <= '0;
      wb_data <= '0;
    end else begin
      if (state == IDLE && start && !abort)
        ir <= instruction;
      if (state == EXEC && !abort)
        wb_data <= is_ldi ? imm : alu_result;
    end
  end

  // Architectural result, zero flag and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      result     <= '0;
      zero       <= 1'b1;
      exec_count <= '0;
    end else begin
      if (rf_we) begin
        result <= wb_data;
        zero   <= (wb_data == '0);
      end
      if (done)
        exec_count <= exec_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a register-file and ALU model.
// Checks cycle-exact strobes, writeback values, abort/start handling, reset and counter wrap.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] instruction;
  logic        busy, done, rf_we;
  logic [2:0]  pst;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr, alu_op;
  logic [3:0]  rf_rdata1, rf_rdata2, rf_wdata, alu_a, alu_b, alu_result, result;
  logic        zero;
  logic [7:0]  exec_count;

  logic        pl_we;
  logic [3:0]  pl_addr, pl_data;
  logic [3:0]  rf [16];

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  exec_sequencer #(.DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .instruction(instruction),
    .busy(busy), .done(done), .pst(pst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .result(result), .zero(zero), .exec_count(exec_count)
  );

  // Register file model: synchronous read, preload port, DUT write port
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 4'h0;
    end else if (pl_we) begin
      rf[pl_addr] <= pl_data;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
    rf_rdata1 <= rf[rf_raddr1];
    rf_rdata2 <= rf[rf_raddr2];
  end

  // ALU model: op 1 adds, op 2 subtracts, everything else yields 0
  always_comb begin
    alu_result = 4'h0;
    case (alu_op)
      4'h1: alu_result = alu_a + alu_b;
      4'h2: alu_result = alu_a - alu_b;
      default: alu_result = 4'h0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_pst"},       32'(pst), 0);
    chk({pfx, "_busy"},      32'(busy), 0);
    chk({pfx, "_done"},      32'(done), 0);
    chk({pfx, "_rf_we"},     32'(rf_we), 0);
    chk({pfx, "_rf_waddr"},  32'(rf_waddr), 0);
    chk({pfx, "_rf_wdata"},  32'(rf_wdata), 0);
    chk({pfx, "_raddr1"},    32'(rf_raddr1), 0);
    chk({pfx, "_raddr2"},    32'(rf_raddr2), 0);
    chk({pfx, "_alu_op"},    32'(alu_op), 0);
    chk({pfx, "_result"},    32'(result), 0);
    chk({pfx, "_zero"},      32'(zero), 1);
    chk({pfx, "_exec_cnt"},  32'(exec_count), 0);
  endtask

  initial begin
    int dones, cyc, last, gap_err;
    logic [7:0] cnt_at_last;

    rst = 1'b1; start = 1'b0; abort = 1'b0; instruction = 16'h0000;
    pl_we = 1'b0; pl_addr = 4'h0; pl_data = 4'h0;
    tick(); tick();
    chk_reset_outputs("rst");

    // Preload r2=5, r3=6
    rst = 1'b0;
    pl_we = 1'b1; pl_addr = 4'h2; pl_data = 4'h5;
    tick();
    pl_addr = 4'h3; pl_data = 4'h6;
    tick();
    pl_we = 1'b0;

    // ADD r6 = r2 + r3; instruction bus changes after acceptance
    instruction = 16'h1236; start = 1'b1;
    tick();
    start = 1'b0; instruction = 16'h0000;
    chk("add_n1_pst", 32'(pst), 1);
    chk("add_n1_busy", 32'(busy), 1);
    chk("add_n1_raddr1", 32'(rf_raddr1), 2);
    chk("add_n1_raddr2", 32'(rf_raddr2), 3);
    chk("add_n1_we", 32'(rf_we), 0);
    tick();
    chk("add_n2_pst", 32'(pst), 2);
    chk("add_n2_alu_op", 32'(alu_op), 1);
    chk("add_n2_alu_a", 32'(alu_a), 5);
    chk("add_n2_alu_b", 32'(alu_b), 6);
    chk("add_n2_we", 32'(rf_we), 0);
    tick();
    chk("add_n3_we", 32'(rf_we), 1);
    chk("add_n3_waddr", 32'(rf_waddr), 6);
    chk("add_n3_wdata", 32'(rf_wdata), 11);
    chk("add_n3_done", 32'(done), 0);
    tick();
    chk("add_n4_done", 32'(done), 1);
    chk("add_n4_we", 32'(rf_we), 0);
    chk("add_n4_busy", 32'(busy), 1);
    chk("add_n4_result", 32'(result), 11);
    chk("add_n4_zero", 32'(zero), 0);
    tick();
    chk("add_n5_done", 32'(done), 0);
    chk("add_n5_busy", 32'(busy), 0);
    chk("add_n5_pst", 32'(pst), 0);
    chk("add_n5_cnt", 32'(exec_count), 1);
    chk("add_r6", 32'(rf[6]), 11);

    // LDI r5 = 9
    instruction = 16'hE905; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("ldi_wdata", 32'(rf_wdata), 9);
    tick();
    chk("ldi_done", 32'(done), 1);
    chk("ldi_result", 32'(result), 9);
    tick();
    chk("ldi_r5", 32'(rf[5]), 9);
    chk("ldi_cnt", 32'(exec_count), 2);

    // NOP: no write, result held, still counted
    instruction = 16'hF000; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("nop_wb_pst", 32'(pst), 3);
    chk("nop_we", 32'(rf_we), 0);
    tick();
    chk("nop_done", 32'(done), 1);
    chk("nop_result", 32'(result), 9);
    tick();
    chk("nop_cnt", 32'(exec_count), 3);

    // Abort during WB
    instruction = 16'h1237; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    #1;
    chk("abt_we", 32'(rf_we), 0);
    chk("abt_done", 32'(done), 0);
    tick();
    abort = 1'b0;
    chk("abt_pst", 32'(pst), 0);
    chk("abt_busy", 32'(busy), 0);
    chk("abt_result", 32'(result), 9);
    chk("abt_cnt", 32'(exec_count), 3);
    chk("abt_r7", 32'(rf[7]), 0);
    tick();
    chk("abt_no_done", 32'(done), 0);

    // Start held through READ/EXEC gives a single completion
    instruction = 16'h1236; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    chk("ign_done_count", 32'(dones), 1);
    chk("ign_cnt", 32'(exec_count), 4);
    chk("ign_result", 32'(result), 11);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_pst", 32'(pst), 0);
    chk("sa_busy", 32'(busy), 0);
    tick();
    chk("sa_pst2", 32'(pst), 0);

    // Reset during EXEC
    instruction = 16'h1236; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_exec_pst", 32'(pst), 2);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;

    // 256 back-to-back NOPs: counter wraps, done spacing is 5 cycles
    instruction = 16'hF000; start = 1'b1;
    dones = 0; cyc = 0; last = 0; gap_err = 0; cnt_at_last = 8'h00;
    while (dones < 256 && cyc < 2000) begin
      tick();
      cyc++;
      if (done) begin
        if (dones > 0 && (cyc - last) != 5) gap_err++;
        if (dones == 255) cnt_at_last = exec_count;
        last = cyc;
        dones++;
      end
    end
    start = 1'b0;
    tick();
    chk("wrap_done_count", 32'(dones), 256);
    chk("wrap_gap_errors", 32'(gap_err), 0);
    chk("wrap_cnt_before", 32'(cnt_at_last), 255);
    chk("wrap_cnt_after", 32'(exec_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Sequences one instruction through the register file and ALU. It accepts the 16-bit instruction assembled by the front-panel IO logic on a `start` pulse, then performs these steps in order:
- reads both source registers;
- drives the ALU;
- captures the result;
- writes it back to the destination register;
- signals completion.

It sits between the IO block, which supplies `instruction`/`start` and displays `result`, and the register file / ALU datapath.

## Interface
Parameters:
- DATA_W, 4, width of register and ALU data
- CNT_W, 8, width of executed-instruction counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request pulse; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE
- instruction  in  16  [15:12] opcode, [11:8] rs1 / immediate, [7:4] rs2, [3:0] rd
- busy  out  1  high in READ, EXEC, WB, DONE
- done  out  1  one-cycle completion pulse
- pst  out  3  current state encoding
- rf_raddr1  out  4  register file read address 1
- rf_raddr2  out  4  register file read address 2
- rf_rdata1  in  DATA_W  read data 1; valid one cycle after address
- rf_rdata2  in  DATA_W  read data 2; valid one cycle after address
- rf_we  out  1  write enable
- rf_waddr  out  4  write address
- rf_wdata  out  DATA_W  write data
- alu_op  out  4  ALU operation code
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- alu_result  in  DATA_W  combinational ALU output
- result  out  DATA_W  last written-back value; held until the next completed instruction
- zero  out  1  result == 0, updated together with result
- exec_count  out  CNT_W  completed-instruction count; wraps

## Operation
- States and encodings: IDLE=0, READ=1, EXEC=2, WB=3, DONE=4. `pst` mirrors the state; codes 5–7 are illegal and recover to IDLE on the next clock.
- IDLE:
  - on `start`=1, latch `instruction` into `ir` and go to READ;
  - otherwise stay in IDLE.
- READ:
  - `rf_raddr1`=ir[11:8], `rf_raddr2`=ir[7:4];
  - go to EXEC.
- EXEC:
  - `alu_op`=ir[15:12], `alu_a`=`rf_rdata1`, `alu_b`=`rf_rdata2`;
  - capture `wb_data` at the clock edge, then go to WB. `wb_data` is:
    - `alu_result` for opcodes 0x0–0xD;
    - ir[11:8], zero-extended or truncated to DATA_W, for opcode 0xE (LDI);
    - don't-care for opcode 0xF (NOP).
- WB:
  - `rf_waddr`=ir[3:0], `rf_wdata`=`wb_data`;
  - `rf_we`=1, except `rf_we`=0 for NOP;
  - `result`/`zero` take `wb_data` at the clock edge, except for NOP, where they are unchanged;
  - go to DONE.
- DONE:
  - `done`=1;
  - `exec_count` increments at the clock edge, NOP included, and wraps from 2^CNT_W−1 to 0;
  - go to IDLE.
- Address/operand outputs:
  - `rf_raddr*` always reflect `ir` fields;
  - `alu_*` always reflect `ir`/`rf_rdata`;
  - `rf_we` and `done` are the only strobes.
- Abort:
  - `abort`=1 in any state forces IDLE on the next clock;
  - in that cycle `rf_we`=0 and `done`=0, even if in WB/DONE;
  - `result`, `zero` and `exec_count` are unchanged;
  - `rst` has priority over `abort`.
- Start outside IDLE is ignored and not queued.
- Start and abort together in IDLE: abort wins, so the block stays in IDLE and `ir` is not loaded.
- `instruction` changes after acceptance have no effect, because `ir` is held.

## Timing
- Reset values: state=IDLE, `ir`=0, `busy`=0, `done`=0, `pst`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `rf_raddr*`=0, `alu_op`=0, `result`=0, `zero`=1, `exec_count`=0.
- Start sampled at edge N gives this sequence:
  - READ during cycle N+1;
  - EXEC during N+2;
  - WB during N+3, with `rf_we` high for exactly that cycle;
  - DONE during N+4, with `done` high for exactly that cycle;
  - IDLE during N+5.
- Latency from start to done is 4 cycles. The earliest next accepted start is in cycle N+5.
- `busy` is registered: high in cycles N+1 through N+4, low otherwise.
- `result`/`zero` are visible from cycle N+4, the same cycle as `done`.
- Register-file contract: `rf_rdata` presented in EXEC corresponds to the addresses driven in READ.

## Test plan
- ADD writeback:
  - setup: reset, then preload r2=5 and r3=6; ALU model returns a+b (mod 16) for op 1;
  - stimulus: `instruction`=0x1236 with a start pulse;
  - response: `rf_raddr1`=2 and `rf_raddr2`=3 in N+1; `rf_we`=1 with `rf_waddr`=6 and `rf_wdata`=0xB only in N+3; `done` only in N+4; `result`=0xB, `zero`=0, `exec_count`=1.
- LDI and NOP:
  - stimulus: 0xE905 → response: r5←9, `result`=9;
  - then stimulus: 0xF000 → response: no `rf_we` pulse, `result` stays 9, `done` in N+4, `exec_count` incremented.
- Abort and start handling:
  - abort asserted during WB → `rf_we`=0 that cycle, no `done`, IDLE next cycle, `result` and `exec_count` unchanged;
  - start pulses during READ/EXEC are ignored, giving only one `done`;
  - start and abort together in IDLE → stays in IDLE.
- Reset mid-operation: rst during EXEC → next cycle shows every output at its reset value, with `zero`=1 and `exec_count`=0.
- Counter wrap (CNT_W=8): run 256 NOPs back-to-back (start issued in each IDLE cycle) → `exec_count` returns to 0; consecutive `done` pulses are exactly 5 cycles apart.
